sram_access_arbiter: RTL and testbench

- Shares the single external 16-bit SRAM between two requesters.
  - Client A: the texture-transfer engine (Atlas, SRC/TRG and RES traffic).
  - Client B: the pixel readout path, which prints or displays TRG/SRC/RES as two-word pixels (R|G, then B|Gray).
- Replaces the hard state-based mux at top level with a round-robin arbiter. A lock mechanism keeps multi-word pixel accesses atomic.
- Registers all SRAM control outputs and returns read data with a fixed latency.

---
 rtl/sram_access_arbiter_if.sv | 57 +++++
 rtl/sram_access_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if
//   Bundles the two client request/response channels and the external SRAM
//   pin set of the SRAM access arbiter.
//   slave  : arbiter side (client requests and SRAM read data in; grants,
//            read responses, SRAM pins and lock_err out).
//   master : environment side (clients and SRAM pads), the mirror image.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // client A
    logic              i_a_req;
    logic              i_a_lock;
    logic              i_a_we;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_wdata;
    logic              o_a_gnt;
    logic              o_a_rvalid;
    logic [DATA_W-1:0] o_a_rdata;
    // client B
    logic              i_b_req;
    logic              i_b_lock;
    logic              i_b_we;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_wdata;
    logic              o_b_gnt;
    logic              o_b_rvalid;
    logic [DATA_W-1:0] o_b_rdata;
    // SRAM pins
    logic [ADDR_W-1:0] o_SRAM_ADDR;
    logic              o_SRAM_WE;
    logic              o_SRAM_OE;
    logic [DATA_W-1:0] o_SRAM_DQ_OUT;
    logic              o_SRAM_DQ_OE;
    logic [DATA_W-1:0] i_SRAM_DQ;
    logic              o_lock_err;

    modport slave (
        input  i_a_req, i_a_lock, i_a_we, i_a_addr, i_a_wdata,
        input  i_b_req, i_b_lock, i_b_we, i_b_addr, i_b_wdata,
        input  i_SRAM_DQ,
        output o_a_gnt, o_a_rvalid, o_a_rdata,
        output o_b_gnt, o_b_rvalid, o_b_rdata,
        output o_SRAM_ADDR, o_SRAM_WE, o_SRAM_OE, o_SRAM_DQ_OUT, o_SRAM_DQ_OE,
        output o_lock_err
    );

    modport master (
        output i_a_req, i_a_lock, i_a_we, i_a_addr, i_a_wdata,
        output i_b_req, i_b_lock, i_b_we, i_b_addr, i_b_wdata,
        output i_SRAM_DQ,
        input  o_a_gnt, o_a_rvalid, o_a_rdata,
        input  o_b_gnt, o_b_rvalid, o_b_rdata,
        input  o_SRAM_ADDR, o_SRAM_WE, o_SRAM_OE, o_SRAM_DQ_OUT, o_SRAM_DQ_OE,
        input  o_lock_err
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Round-robin arbiter sharing one 16-bit SRAM between the texture-transfer
//   engine (client A) and the pixel readout path (client B). A client may
//   lock ownership for multi-word accesses; a lock held for MAX_LOCK grants
//   while the other client waits is force-broken.
//   Ports:
//     i_clk   : system clock
//     i_rst_n : asynchronous active-low reset
//     bus     : client channels + SRAM pins (sram_access_arbiter_if.slave)
//   Timing: gnt is combinational in cycle t, the command is on the SRAM pins
//   in t+1, read data is sampled at the end of t+1 and returned with rvalid
//   in t+2. o_lock_err pulses in the cycle after the forced hand-over grant.
module sram_access_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sram_access_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {S_FREE, S_LOCK_A, S_LOCK_B} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;     // 0 = A favoured, 1 = B favoured
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_a, gnt_b, brk;

    // ---------------- arbitration FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FREE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        brk     = 1'b0;
        case (state_q)
            S_FREE: begin
                if (bus.i_a_req && (!bus.i_b_req || !ptr_q)) gnt_a = 1'b1;
                else if (bus.i_b_req)                          gnt_b = 1'b1;
            end
            S_LOCK_A: begin
                // Lock exhausted and B waiting: hand over in this same cycle
                // so no idle slot appears on the SRAM.
                if (cnt_q >= CNT_MAX && bus.i_b_req) begin
                    gnt_b = 1'b1;
                    brk   = 1'b1;
                end else if (bus.i_a_req) begin
                    gnt_a = 1'b1;
                end else begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end
            end
            S_LOCK_B: begin
                if (cnt_q >= CNT_MAX && bus.i_a_req) begin
                    gnt_a = 1'b1;
                    brk   = 1'b1;
                end else if (bus.i_b_req) begin
                    gnt_b = 1'b1;
                end else begin
                    state_d = S_FREE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_FREE;
                cnt_d   = '0;
            end
        endcase

        // Every grant hands priority to the other client; lock bit of the
        // granted access decides whether ownership is kept.
        if (gnt_a) begin
            ptr_d = 1'b1;
            if (bus.i_a_lock) begin
                state_d = S_LOCK_A;
                if (state_q == S_LOCK_A) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                else                     cnt_d = CNT_W'(1);
            end else begin
                state_d = S_FREE;
                cnt_d   = '0;
            end
        end else if (gnt_b) begin
            ptr_d = 1'b0;
            if (bus.i_b_lock) begin
                state_d = S_LOCK_B;
                if (state_q == S_LOCK_B) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                else                     cnt_d = CNT_W'(1);
            end else begin
                state_d = S_FREE;
                cnt_d   = '0;
            end
        end
    end

    // Grants are masked during reset so all outputs show reset values.
    assign bus.o_a_gnt = gnt_a & i_rst_n;
    assign bus.o_b_gnt = gnt_b & i_rst_n;

    // ---------------- SRAM command / read return ----------------
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;

    assign c_we    = gnt_b ? bus.i_b_we    : bus.i_a_we;
    assign c_addr  = gnt_b ? bus.i_b_addr  : bus.i_a_addr;
    assign c_wdata = gnt_b ? bus.i_b_wdata : bus.i_a_wdata;

    logic              sram_we_n, sram_oe_n, dq_oe, lock_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] dq_out;
    logic              rd_pend, rd_own_b;   // read on the pins this cycle, owner
    logic              a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_oe     <= 1'b0;
            sram_addr <= '0;
            dq_out    <= '0;
            rd_pend   <= 1'b0;
            rd_own_b  <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            lock_err  <= 1'b0;
        end else begin
            // idle unless a command was granted; address and DQ_OUT hold
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            dq_oe     <= 1'b0;
            rd_pend   <= 1'b0;
            lock_err  <= brk;
            if (gnt_a || gnt_b) begin
                sram_addr <= c_addr;
                rd_own_b  <= gnt_b;
                if (c_we) begin
                    sram_we_n <= 1'b0;
                    dq_oe     <= 1'b1;
                    dq_out    <= c_wdata;
                end else begin
                    sram_oe_n <= 1'b0;
                    rd_pend   <= 1'b1;
                end
            end
            // sample DQ at the end of the read's pin cycle
            a_rvalid <= rd_pend && !rd_own_b;
            b_rvalid <= rd_pend &&  rd_own_b;
            if (rd_pend && !rd_own_b) a_rdata <= bus.i_SRAM_DQ;
            if (rd_pend &&  rd_own_b) b_rdata <= bus.i_SRAM_DQ;
        end
    end

    assign bus.o_SRAM_ADDR   = sram_addr;
    assign bus.o_SRAM_WE     = sram_we_n;
    assign bus.o_SRAM_OE     = sram_oe_n;
    assign bus.o_SRAM_DQ_OUT = dq_out;
    assign bus.o_SRAM_DQ_OE  = dq_oe;
    assign bus.o_a_rvalid    = a_rvalid;
    assign bus.o_b_rvalid    = b_rvalid;
    assign bus.o_a_rdata     = a_rdata;
    assign bus.o_b_rdata     = b_rdata;
    assign bus.o_lock_err    = lock_err;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter
//   Directed bench for sram_access_arbiter: a small SRAM model on the pins,
//   a transaction-level reference model checked every cycle, and literal
//   expectations for the listed scenarios.
module tb_sram_access_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int ML = 4;

    logic i_clk;
    logic i_rst_n;
    int   vectors;
    int   miscompares;

    sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] pat(input int k);
        if (k == 'h32) return 16'h1234;
        return 16'hA500 ^ 16'(k * 3);
    endfunction

    // ---------------- SRAM device model ----------------
    logic [15:0] sram [0:255];
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 256; k++) sram[k] <= pat(k);
        end else if (!bus.o_SRAM_WE && bus.o_SRAM_DQ_OE) begin
            sram[bus.o_SRAM_ADDR[7:0]] <= bus.o_SRAM_DQ_OUT;
        end
    end
    assign bus.i_SRAM_DQ = sram[bus.o_SRAM_ADDR[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    initial begin : model
        int owner, streak, prefer, win;   // client ids: 0 none, 1 A, 2 B
        bit forced, c_we, c_lock, xr, yr;
        logic [AW-1:0] c_addr, e_addr;
        logic [DW-1:0] c_wd, e_dqo, e_ard, e_brd, s1d, s2d;
        logic e_we, e_oe, e_dqoe, e_err;
        int s1c, s2c;
        logic [15:0] smem [0:255];
        owner = 0; streak = 0; prefer = 1;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                chk("rst_a_gnt", 32'(bus.o_a_gnt), 0);
                chk("rst_b_gnt", 32'(bus.o_b_gnt), 0);
                chk("rst_we", 32'(bus.o_SRAM_WE), 1);
                chk("rst_oe", 32'(bus.o_SRAM_OE), 1);
                chk("rst_addr", 32'(bus.o_SRAM_ADDR), 0);
                chk("rst_dqo", 32'(bus.o_SRAM_DQ_OUT), 0);
                chk("rst_dqoe", 32'(bus.o_SRAM_DQ_OE), 0);
                chk("rst_rvalid", {30'd0, bus.o_a_rvalid, bus.o_b_rvalid}, 0);
                chk("rst_rdata", {bus.o_a_rdata, bus.o_b_rdata}, 0);
                chk("rst_lock_err", 32'(bus.o_lock_err), 0);
                owner = 0; streak = 0; prefer = 1;
                e_addr = '0; e_dqo = '0; e_we = 1; e_oe = 1; e_dqoe = 0; e_err = 0;
                e_ard = '0; e_brd = '0; s1c = 0; s2c = 0; s1d = '0; s2d = '0;
                for (int k = 0; k < 256; k++) smem[k] = pat(k);
            end else begin
                // who is entitled to the SRAM this cycle
                win = 0; forced = 0;
                if (owner == 0) begin
                    if (bus.i_a_req && bus.i_b_req) win = prefer;
                    else if (bus.i_a_req)           win = 1;
                    else if (bus.i_b_req)           win = 2;
                end else begin
                    xr = (owner == 1) ? bus.i_a_req : bus.i_b_req;
                    yr = (owner == 1) ? bus.i_b_req : bus.i_a_req;
                    if (streak >= ML && yr) begin win = 3 - owner; forced = 1; end
                    else if (xr)            win = owner;
                end
                chk("a_gnt", 32'(bus.o_a_gnt), 32'(win == 1));
                chk("b_gnt", 32'(bus.o_b_gnt), 32'(win == 2));
                chk("sram_addr", 32'(bus.o_SRAM_ADDR), 32'(e_addr));
                chk("sram_we", 32'(bus.o_SRAM_WE), 32'(e_we));
                chk("sram_oe", 32'(bus.o_SRAM_OE), 32'(e_oe));
                chk("sram_dqoe", 32'(bus.o_SRAM_DQ_OE), 32'(e_dqoe));
                chk("sram_dqout", 32'(bus.o_SRAM_DQ_OUT), 32'(e_dqo));
                chk("lock_err", 32'(bus.o_lock_err), 32'(e_err));
                chk("a_rvalid", 32'(bus.o_a_rvalid), 32'(s2c == 1));
                chk("b_rvalid", 32'(bus.o_b_rvalid), 32'(s2c == 2));
                if (s2c == 1) e_ard = s2d;
                if (s2c == 2) e_brd = s2d;
                chk("a_rdata", 32'(bus.o_a_rdata), 32'(e_ard));
                chk("b_rdata", 32'(bus.o_b_rdata), 32'(e_brd));

                // advance to the next cycle
                s2c = s1c; s2d = s1d; s1c = 0;
                e_err = forced;
                e_we = 1; e_oe = 1; e_dqoe = 0;
                if (win != 0) begin
                    c_we   = (win == 1) ? bus.i_a_we    : bus.i_b_we;
                    c_lock = (win == 1) ? bus.i_a_lock  : bus.i_b_lock;
                    c_addr = (win == 1) ? bus.i_a_addr  : bus.i_b_addr;
                    c_wd   = (win == 1) ? bus.i_a_wdata : bus.i_b_wdata;
                    e_addr = c_addr;
                    if (c_we) begin
                        e_we = 0; e_dqoe = 1; e_dqo = c_wd;
                        smem[c_addr[7:0]] = c_wd;
                    end else begin
                        e_oe = 0; s1c = win; s1d = smem[c_addr[7:0]];
                    end
                    prefer = 3 - win;
                    if (c_lock) begin
                        if (owner == win) streak = (streak < ML) ? streak + 1 : ML;
                        else              streak = 1;
                        owner = win;
                    end else begin
                        owner = 0; streak = 0;
                    end
                end else if (owner != 0) begin
                    owner = 0; streak = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic lock, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.i_a_req = req; bus.i_a_lock = lock; bus.i_a_we = we;
        bus.i_a_addr = addr; bus.i_a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic lock, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.i_b_req = req; bus.i_b_lock = lock; bus.i_b_we = we;
        bus.i_b_addr = addr; bus.i_b_wdata = wd;
    endtask

    initial begin
        int na, nb;
        vectors = 0; miscompares = 0;
        i_rst_n = 1'b0;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // A-only read of 0x00032
        set_a(1, 0, 0, 20'h00032, '0);
        @(negedge i_clk); chk("t1_gnt", 32'(bus.o_a_gnt), 1);
        tick(); set_a(0, 0, 0, '0, '0);
        @(negedge i_clk);
        chk("t1_addr", 32'(bus.o_SRAM_ADDR), 32'h32);
        chk("t1_oe", 32'(bus.o_SRAM_OE), 0);
        tick();
        @(negedge i_clk);
        chk("t1_rvalid", 32'(bus.o_a_rvalid), 1);
        chk("t1_rdata", 32'(bus.o_a_rdata), 32'h1234);

        // B write 0xABCD to 0x00010, read back through A
        tick(); set_b(1, 0, 1, 20'h00010, 16'hABCD);
        @(negedge i_clk); chk("t2_gnt", 32'(bus.o_b_gnt), 1);
        tick(); set_b(0, 0, 0, '0, '0);
        @(negedge i_clk);
        chk("t2_we", 32'(bus.o_SRAM_WE), 0);
        chk("t2_dqoe", 32'(bus.o_SRAM_DQ_OE), 1);
        chk("t2_dqout", 32'(bus.o_SRAM_DQ_OUT), 32'hABCD);
        tick(); set_a(1, 0, 0, 20'h00010, '0);
        @(negedge i_clk); chk("t2_rd_gnt", 32'(bus.o_a_gnt), 1);
        tick(); set_a(0, 0, 0, '0, '0);
        tick();
        @(negedge i_clk);
        chk("t2_rd_rvalid", 32'(bus.o_a_rvalid), 1);
        chk("t2_rd_rdata", 32'(bus.o_a_rdata), 32'hABCD);

        // both clients continuously, no lock, fresh reset
        tick(); i_rst_n = 1'b0;
        tick(); i_rst_n = 1'b1;
        tick();
        set_a(1, 0, 0, 20'h00001, '0);
        set_b(1, 0, 0, 20'h00002, '0);
        na = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            chk("t3_alt", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, (i % 2 == 0) ? 2 : 1);
            na += int'(bus.o_a_gnt);
            nb += int'(bus.o_b_gnt);
            tick();
        end
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        chk("t3_a_share", 32'(na), 4);
        chk("t3_b_share", 32'(nb), 4);

        // pixel pair on B under lock while A requests throughout
        tick(); set_a(1, 0, 0, 20'h00040, '0);
        @(negedge i_clk); chk("t4_pre_gnt", 32'(bus.o_a_gnt), 1);
        tick(); set_a(1, 0, 0, 20'h00041, '0); set_b(1, 1, 0, 20'd50, '0);
        @(negedge i_clk); chk("t4_g0", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 1);
        tick(); set_b(1, 0, 0, 20'd51, '0);
        @(negedge i_clk); chk("t4_g1", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 1);
        tick(); set_b(0, 0, 0, '0, '0);
        @(negedge i_clk);
        chk("t4_g2", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 2);
        chk("t4_rv0", 32'(bus.o_b_rvalid), 1);
        chk("t4_rd0", 32'(bus.o_b_rdata), 32'h1234);
        tick(); set_a(0, 0, 0, '0, '0);
        @(negedge i_clk);
        chk("t4_rv1", 32'(bus.o_b_rvalid), 1);

        // A holds lock for 6 accesses while B waits; MAX_LOCK = 4
        tick(); set_a(1, 1, 0, 20'h00060, '0);
        @(negedge i_clk); chk("t5_c0", 32'(bus.o_a_gnt), 1);
        tick(); set_b(1, 0, 0, 20'h00070, '0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge i_clk);
            if (i <= 3) chk("t5_a_gnt", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 2);
            if (i == 4) begin
                chk("t5_force_b", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 1);
                chk("t5_err_early", 32'(bus.o_lock_err), 0);
            end
            if (i == 5) chk("t5_lock_err", 32'(bus.o_lock_err), 1);
            tick();
            if (i == 4) set_b(0, 0, 0, '0, '0);
        end
        set_a(0, 0, 0, '0, '0);
        tick();

        // reset one cycle after a read grant
        tick(); set_a(1, 0, 0, 20'h00005, '0);
        @(negedge i_clk); chk("t6_gnt", 32'(bus.o_a_gnt), 1);
        tick(); set_a(0, 0, 0, '0, '0); i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("t6_oe", 32'(bus.o_SRAM_OE), 1);
        chk("t6_addr", 32'(bus.o_SRAM_ADDR), 0);
        tick(); i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("t6_no_rvalid", 32'(bus.o_a_rvalid), 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
